// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Function : Iterative shifter with valid/ready handshakes. It shifts STEP bit
//            positions per cycle. Define SEQ_SHIFTER_ROTATE_EN to enable the
//            ROL/ROR opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter #(
    parameter int   WIDTH = 16,
    parameter int   STEP  = 1,
    localparam int  AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [AMT_W-1:0] imm_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    // One extra bit so the counter can also represent STEP == WIDTH.
    localparam int CNT_W = AMT_W + 1;
    localparam logic [CNT_W-1:0] c_step  = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] c_half  = CNT_W'(WIDTH / 2);
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MD_SHL = 3'd0,
        MD_SHR = 3'd1,
        MD_SRA = 3'd2,
        MD_ROL = 3'd3,
        MD_ROR = 3'd4
    } mode_t;

    state_t           r_state_q,  w_state_d;
    mode_t            r_mode_q,   w_mode_d;
    logic [WIDTH-1:0] r_data_q,   w_data_d;
    logic [WIDTH-1:0] r_result_q, w_result_d;
    logic [CNT_W-1:0] r_rem_q,    w_rem_d;
    logic [CNT_W-1:0] w_step;
    logic [WIDTH-1:0] w_shifted;

    assign w_step = (r_rem_q >= c_step) ? c_step : r_rem_q;

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [CNT_W-1:0] w_back;
    assign w_back = c_width - w_step;
`endif

    always_comb begin
        w_shifted = r_data_q;
        case (r_mode_q)
            MD_SHL:  w_shifted = r_data_q << w_step;
            MD_SHR:  w_shifted = r_data_q >> w_step;
            MD_SRA:  w_shifted = $unsigned($signed(r_data_q) >>> w_step);
`ifdef SEQ_SHIFTER_ROTATE_EN
            MD_ROL:  w_shifted = (r_data_q << w_step) | (r_data_q >> w_back);
            MD_ROR:  w_shifted = (r_data_q >> w_step) | (r_data_q << w_back);
`endif
            default: w_shifted = r_data_q;
        endcase
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_mode_d   = r_mode_q;
        w_data_d   = r_data_q;
        w_result_d = r_result_q;
        w_rem_d    = r_rem_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_data_d = src_a;
                    w_mode_d = MD_SHL;
                    w_rem_d  = {1'b0, imm_amt};
                    case (op)
                        4'h0: w_mode_d = MD_SHL;
                        4'h1: w_mode_d = MD_SHR;
                        4'h2: w_mode_d = MD_SRA;
                        4'h4: begin
                            w_mode_d = src_b[AMT_W] ? MD_SHR : MD_SHL;
                            w_rem_d  = {1'b0, src_b[AMT_W-1:0]};
                        end
                        4'hF: begin
                            // LUI walks src_b up through the normal shift path.
                            w_data_d = src_b;
                            w_rem_d  = c_half;
                        end
`ifdef SEQ_SHIFTER_ROTATE_EN
                        4'h8: w_mode_d = MD_ROL;
                        4'h9: w_mode_d = MD_ROR;
`endif
                        default: w_rem_d = '0;
                    endcase
                    if (w_rem_d == '0) begin
                        w_state_d  = ST_DONE;
                        w_result_d = w_data_d;
                    end else begin
                        w_state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                w_data_d = w_shifted;
                w_rem_d  = r_rem_q - w_step;
                if (w_rem_d == '0) begin
                    w_state_d  = ST_DONE;
                    w_result_d = w_shifted;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_mode_q   <= MD_SHL;
            r_data_q   <= '0;
            r_result_q <= '0;
            r_rem_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_mode_q   <= w_mode_d;
            r_data_q   <= w_data_d;
            r_result_q <= w_result_d;
            r_rem_q    <= w_rem_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE) && !reset;
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q == ST_SHIFT) || (r_state_q == ST_DONE);
    assign result    = r_result_q;

endmodule
`default_nettype wire
